l1_data_cache: RTL and testbench
================================

Name: l1_data_cache

Overview:
- Blocking L1 data cache between the core load/store port and the L2.
- 2-way set-associative, one 32-bit word per line, write-back and write-allocate, 1-bit LRU per set.
- Hits complete with no L2 traffic. Misses fetch the line from L2, writing back a dirty victim first.
- Single outstanding request; the current FSM state is exported on c_state for debug.

Parameters:
- CACHE_SIZE, 4096, total data capacity in bytes.
- BLOCK_SIZE, 4, line size in bytes (one 32-bit word).
- ASSOCIATIVITY, 2, ways per set; the LRU scheme is defined for 2 only.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- Derived: NUM_SETS=512, OFFSET=2 bits, INDEX=9 bits [10:2], TAG=21 bits [31:11].

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- write_enable  in  1  store request.
- read_enable  in  1  load request.
- request_address  in  32  byte address of the request.
- write_data  in  32  store data.
- response_data  out  32  load result, registered.
- c_state  out  2  FSM state: 0=IDLE, 1=COMPARE_TAG, 2=ALLOCATE, 3=WRITE_BACK.
- l2_response_data  in  32  fill data from L2.
- l2_ready  in  1  L2 completion strobe (one cycle).
- l2_request  out  1  L2 transaction request.
- l2_write_enable  out  1  1 = write-back, 0 = fill read.
- l2_address  out  32  L2 line address, offset bits zero.
- l2_write_data  out  32  victim data during write-back.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all valid, dirty and LRU bits cleared.
  - response_data, l2_request, l2_write_enable, l2_address and l2_write_data = 0.
  - A reset in the middle of an L2 transaction abandons it; l2_request drops on the next edge.
- IDLE:
  - If write_enable or read_enable is set, latch address, write_data and op into request registers, then go to COMPARE_TAG.
  - If both enables are set, the op is a write.
  - Enables are ignored in all states other than IDLE.
- COMPARE_TAG, hit (valid and tag match in some way):
  - Read: response_data <= way data.
  - Write: way data <= write_data, dirty=1.
  - LRU bit <= the other way; go to IDLE.
  - Resulting latency: request seen in IDLE at edge N, response_data valid after edge N+1.
- COMPARE_TAG, miss:
  - Victim = an invalid way (way 0 first), else the LRU way.
  - Victim dirty: l2_request=1, l2_write_enable=1, l2_address={victim tag, index, 2'b0}, l2_write_data=victim data; go to WRITE_BACK.
  - Otherwise: l2_request=1, l2_write_enable=0, l2_address={req tag, index, 2'b0}; go to ALLOCATE.
- WRITE_BACK:
  - Hold the L2 outputs until l2_ready=1 is sampled.
  - Then clear the victim's dirty bit, switch outputs to a fill read of the requested line, and go to ALLOCATE.
- ALLOCATE:
  - Hold l2_request until l2_ready=1 is sampled.
  - Then write the victim way: data=l2_response_data, tag=request tag, valid=1, dirty=0.
  - Drop l2_request and l2_write_enable; go to COMPARE_TAG, which now hits and completes the op (read returns the data; write merges write_data and sets dirty).
- L2 handshake: l2_request/l2_address/l2_write_data stay stable from assertion until the ready edge. L2 drives ready for exactly one cycle.
- Latency with a 1-cycle L2:
  - Hit ≤ 2 cycles.
  - Clean miss ≤ 5 cycles.
  - Dirty miss ≤ 8 cycles.
- LRU update: LRU is updated only on completion in COMPARE_TAG.
- response_data holds its last value until the next completed read.
- Writes never change response_data.

Decomposition:
- Package l1_dcache_pkg holds:
  - state enum (IDLE, COMPARE_TAG, ALLOCATE, WRITE_BACK, 2-bit, encoding above);
  - width localparams (TAG/INDEX/OFFSET);
  - line record struct {valid, dirty, tag, data}.
- Sub-module l1_dcache_array: per-way tag/data/valid/dirty storage plus the LRU bit vector, with synchronous write, combinational read, and a hit/way output. The FSM and L2 interface stay in the top module.

Test Plan:
L2 model contents: 0x00000832→0xEEEEEEEE, 0xABCDE832→0xFFFFFFFF, 0xAAAAA832→0xABCDEFAB, 0xFFFFF832→0xFEDCBAFE.
- Reset, then read 0x00000832 → ALLOCATE with l2_address=0x00000830, l2_write_enable=0; response_data=0xEEEEEEEE within 5 cycles. Next read the same address → hit, no l2_request, 2 cycles.
- Fill 0x00000832 and 0xABCDE832 (same set 0x0C), read 0x00000832, then read 0xAAAAA832 → evicts 0xABCDE832 (LRU). Re-reading 0xABCDE832 then misses.
- Reads of 0x00000832 then 0xABCDE832 (both hits) → LRU points at way 0. Write 0xBEEFDEAD to 0xABCDE832 → write hit, dirty set, no L2 traffic.
- Continuing the previous case, read 0xAAAAA832 → evicts clean 0x00000832. Then read 0xFFFFF832 → WRITE_BACK with l2_write_enable=1, l2_address=0xABCDE830, l2_write_data=0xBEEFDEAD, then fill; response_data=0xFEDCBAFE within 8 cycles.
- After the previous case: reads of 0xAAAAA832 and 0xFFFFF832 hit; read 0x00000832 → 0xEEEEEEEE; read 0xABCDE832 → 0xFFFFFFFF; c_state is 0 between requests.
- Assert reset during ALLOCATE → c_state=0 and l2_request=0 next cycle; a following read of a previously cached address misses.

Source files
------------

// File: rtl/l1_dcache_pkg.sv
// ----------------------------------------------------------------------------
// l1_dcache_pkg
// Shared types and geometry for the L1 data cache: FSM state encoding (also
// exported on c_state), address field widths and the per-line record.
// Geometry below matches the default top-level parameters
// (4 KiB, 4-byte lines, 2 ways -> 512 sets).
// ----------------------------------------------------------------------------
package l1_dcache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned INDEX_W  = 9;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned NUM_SETS = 1 << INDEX_W;
  localparam int unsigned NUM_WAYS = 2;

  // Encoding is visible to software/debug through c_state.
  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StCompareTag = 2'd1,
    StAllocate   = 2'd2,
    StWriteBack  = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  // Line-aligned L2 address from a tag and set index.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// ----------------------------------------------------------------------------
// l1_dcache_array
// Two-way tag/data/valid/dirty storage plus one LRU bit per set.
// Reads are combinational at i_index; writes land on the rising edge.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset (clears valid,
//                         dirty and LRU; tag/data are left as-is)
//   i_index, i_tag        set being looked up and tag to compare against
//   o_line0, o_line1      full line record of each way at i_index
//   o_hit, o_hit_way      tag match in a valid way, and which way
//   o_lru                 LRU bit of the set (the way to evict next)
//   i_wr_en/way/line      whole-line write into (i_wr_way, i_index)
//   i_lru_we, i_lru_val   LRU bit update for i_index
// ----------------------------------------------------------------------------
module l1_dcache_array
  import l1_dcache_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INDEX_W-1:0] i_index,
  input  logic [TAG_W-1:0]   i_tag,
  output line_t              o_line0,
  output line_t              o_line1,
  output logic               o_hit,
  output logic               o_hit_way,
  output logic               o_lru,
  input  logic               i_wr_en,
  input  logic               i_wr_way,
  input  line_t              i_wr_line,
  input  logic               i_lru_we,
  input  logic               i_lru_val
);

  logic [NUM_SETS-1:0] r_valid [NUM_WAYS];
  logic [NUM_SETS-1:0] r_dirty [NUM_WAYS];
  logic [NUM_SETS-1:0] r_lru;
  logic [TAG_W-1:0]    r_tag   [NUM_WAYS][NUM_SETS];
  logic [DATA_W-1:0]   r_data  [NUM_WAYS][NUM_SETS];

  logic w_hit0;
  logic w_hit1;

  // Status bits: these need reset so the cache starts empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      r_lru <= '0;
    end else begin
      if (i_wr_en) begin
        r_valid[i_wr_way][i_index] <= i_wr_line.valid;
        r_dirty[i_wr_way][i_index] <= i_wr_line.dirty;
      end
      if (i_lru_we) begin
        r_lru[i_index] <= i_lru_val;
      end
    end
  end

  // Tag/data are qualified by valid, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_way][i_index]  <= i_wr_line.tag;
      r_data[i_wr_way][i_index] <= i_wr_line.data;
    end
  end

  always_comb begin
    o_line0.valid = r_valid[0][i_index];
    o_line0.dirty = r_dirty[0][i_index];
    o_line0.tag   = r_tag[0][i_index];
    o_line0.data  = r_data[0][i_index];
    o_line1.valid = r_valid[1][i_index];
    o_line1.dirty = r_dirty[1][i_index];
    o_line1.tag   = r_tag[1][i_index];
    o_line1.data  = r_data[1][i_index];
  end

  assign w_hit0    = o_line0.valid && (o_line0.tag == i_tag);
  assign w_hit1    = o_line1.valid && (o_line1.tag == i_tag);
  assign o_hit     = w_hit0 || w_hit1;
  assign o_hit_way = !w_hit0;
  assign o_lru     = r_lru[i_index];

endmodule

// File: rtl/l1_data_cache.sv
// ----------------------------------------------------------------------------
// l1_data_cache
// Blocking 2-way set-associative write-back / write-allocate L1 data cache,
// one 32-bit word per line, one outstanding request.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   write_enable, read_enable  core request strobes (sampled only in IDLE,
//                              write wins if both are set)
//   request_address            byte address of the request
//   write_data                 store data
//   response_data              registered load result, held until next read
//   c_state                    current FSM state for debug
//   l2_request                 L2 transaction valid, held until l2_ready
//   l2_write_enable            1 = victim write-back, 0 = line fill
//   l2_address, l2_write_data  line-aligned L2 address and victim data
//   l2_response_data, l2_ready fill data and one-cycle completion strobe
// ----------------------------------------------------------------------------
module l1_data_cache
  import l1_dcache_pkg::*;
#(
  parameter int unsigned CACHE_SIZE    = 4096,
  parameter int unsigned BLOCK_SIZE    = 4,
  parameter int unsigned ASSOCIATIVITY = 2,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] request_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] response_data,
  output logic [1:0]            c_state,
  input  logic [DATA_WIDTH-1:0] l2_response_data,
  input  logic                  l2_ready,
  output logic                  l2_request,
  output logic                  l2_write_enable,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [DATA_WIDTH-1:0] l2_write_data
);

  localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
  localparam int unsigned IDX_W = $clog2(CACHE_SIZE / (BLOCK_SIZE * ASSOCIATIVITY));

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_wdata;
  logic                  r_req_write;
  logic                  r_victim;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  line_t              w_line0;
  line_t              w_line1;
  logic               w_hit;
  logic               w_hit_way;
  logic               w_lru;
  line_t              w_hit_line;
  logic               w_victim_sel;
  line_t              w_sel_line;
  line_t              w_victim_line;
  logic               w_wr_en;
  logic               w_wr_way;
  line_t              w_wr_line;
  logic               w_lru_we;
  logic               w_lru_val;
  logic               w_unused_offset;

  // All lookups after IDLE use the latched request, not the live port.
  assign w_index         = r_req_addr[OFF_W +: IDX_W];
  assign w_tag           = r_req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign w_unused_offset = ^r_req_addr[OFF_W-1:0];

  l1_dcache_array u_array (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_index   (w_index),
    .i_tag     (w_tag),
    .o_line0   (w_line0),
    .o_line1   (w_line1),
    .o_hit     (w_hit),
    .o_hit_way (w_hit_way),
    .o_lru     (w_lru),
    .i_wr_en   (w_wr_en),
    .i_wr_way  (w_wr_way),
    .i_wr_line (w_wr_line),
    .i_lru_we  (w_lru_we),
    .i_lru_val (w_lru_val)
  );

  assign w_hit_line = w_hit_way ? w_line1 : w_line0;

  // Prefer an empty way (way 0 first) before evicting the LRU way.
  assign w_victim_sel  = !w_line0.valid ? 1'b0 : (!w_line1.valid ? 1'b1 : w_lru);
  assign w_sel_line    = w_victim_sel ? w_line1 : w_line0;
  assign w_victim_line = r_victim ? w_line1 : w_line0;

  // Array write port and LRU update, decoded from the current state.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_way  = 1'b0;
    w_wr_line = '0;
    w_lru_we  = 1'b0;
    w_lru_val = 1'b0;
    unique case (r_state)
      StCompareTag: begin
        if (w_hit) begin
          w_lru_we  = 1'b1;
          w_lru_val = ~w_hit_way;
          if (r_req_write) begin
            w_wr_en         = 1'b1;
            w_wr_way        = w_hit_way;
            w_wr_line.valid = 1'b1;
            w_wr_line.dirty = 1'b1;
            w_wr_line.tag   = w_tag;
            w_wr_line.data  = r_req_wdata;
          end
        end
      end
      StWriteBack: begin
        if (l2_ready) begin
          // Victim now matches L2; keep it valid until the fill replaces it.
          w_wr_en         = 1'b1;
          w_wr_way        = r_victim;
          w_wr_line       = w_victim_line;
          w_wr_line.dirty = 1'b0;
        end
      end
      StAllocate: begin
        if (l2_ready) begin
          w_wr_en         = 1'b1;
          w_wr_way        = r_victim;
          w_wr_line.valid = 1'b1;
          w_wr_line.dirty = 1'b0;
          w_wr_line.tag   = w_tag;
          w_wr_line.data  = l2_response_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= StIdle;
      r_req_addr      <= '0;
      r_req_wdata     <= '0;
      r_req_write     <= 1'b0;
      r_victim        <= 1'b0;
      response_data   <= '0;
      l2_request      <= 1'b0;
      l2_write_enable <= 1'b0;
      l2_address      <= '0;
      l2_write_data   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (write_enable || read_enable) begin
            r_req_addr  <= request_address;
            r_req_wdata <= write_data;
            r_req_write <= write_enable;
            r_state     <= StCompareTag;
          end
        end
        StCompareTag: begin
          if (w_hit) begin
            if (!r_req_write) begin
              response_data <= w_hit_line.data;
            end
            r_state <= StIdle;
          end else begin
            r_victim   <= w_victim_sel;
            l2_request <= 1'b1;
            if (w_sel_line.valid && w_sel_line.dirty) begin
              l2_write_enable <= 1'b1;
              l2_address      <= line_addr(w_sel_line.tag, w_index);
              l2_write_data   <= w_sel_line.data;
              r_state         <= StWriteBack;
            end else begin
              l2_write_enable <= 1'b0;
              l2_address      <= line_addr(w_tag, w_index);
              r_state         <= StAllocate;
            end
          end
        end
        StWriteBack: begin
          // l2_request stays high: the fill follows straight on.
          if (l2_ready) begin
            l2_write_enable <= 1'b0;
            l2_address      <= line_addr(w_tag, w_index);
            r_state         <= StAllocate;
          end
        end
        StAllocate: begin
          // Back to COMPARE_TAG, which now hits and completes the op.
          if (l2_ready) begin
            l2_request      <= 1'b0;
            l2_write_enable <= 1'b0;
            r_state         <= StCompareTag;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign c_state = r_state;

endmodule

// File: tb/tb_l1_data_cache.sv
// ----------------------------------------------------------------------------
// tb_l1_data_cache
// Directed bench for l1_data_cache with a small read-only L2 model that
// answers each request one cycle after it sees it.
// ----------------------------------------------------------------------------
module tb_l1_data_cache;

  logic        clk;
  logic        reset;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] request_address;
  logic [31:0] write_data;
  logic [31:0] response_data;
  logic [1:0]  c_state;
  logic [31:0] l2_response_data;
  logic        l2_ready;
  logic        l2_request;
  logic        l2_write_enable;
  logic [31:0] l2_address;
  logic [31:0] l2_write_data;

  int n_checks = 0;
  int n_errors = 0;

  // Per-request observations.
  int          cycles;
  logic        saw_l2;
  logic        saw_wb;
  logic        saw_alloc;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        al_we;
  logic [31:0] al_addr;

  localparam logic [31:0] A = 32'h0000_0832;
  localparam logic [31:0] B = 32'hABCD_E832;
  localparam logic [31:0] C = 32'hAAAA_A832;
  localparam logic [31:0] D = 32'hFFFF_F832;

  l1_data_cache dut (
    .clk              (clk),
    .reset            (reset),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .request_address  (request_address),
    .write_data       (write_data),
    .response_data    (response_data),
    .c_state          (c_state),
    .l2_response_data (l2_response_data),
    .l2_ready         (l2_ready),
    .l2_request       (l2_request),
    .l2_write_enable  (l2_write_enable),
    .l2_address       (l2_address),
    .l2_write_data    (l2_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] l2_mem(input logic [31:0] a);
    case (a)
      32'h0000_0830: return 32'hEEEE_EEEE;
      32'hABCD_E830: return 32'hFFFF_FFFF;
      32'hAAAA_A830: return 32'hABCD_EFAB;
      32'hFFFF_F830: return 32'hFEDC_BAFE;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  // One-cycle L2: ready pulses for one cycle after a request is seen.
  always @(posedge clk) begin
    if (reset) begin
      l2_ready         <= 1'b0;
      l2_response_data <= '0;
    end else begin
      l2_ready         <= l2_request && !l2_ready;
      l2_response_data <= l2_mem(l2_address);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request and follow it until the FSM is back in IDLE.
  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    write_enable    = wr;
    read_enable     = !wr;
    request_address = addr;
    write_data      = wd;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    cycles    = 1;
    saw_l2    = 1'b0;
    saw_wb    = 1'b0;
    saw_alloc = 1'b0;
    while (c_state != 2'd0 && cycles < 20) begin
      if (l2_request) saw_l2 = 1'b1;
      if (c_state == 2'd3) begin
        saw_wb  = 1'b1;
        wb_we   = l2_write_enable;
        wb_addr = l2_address;
        wb_data = l2_write_data;
      end
      if (c_state == 2'd2) begin
        saw_alloc = 1'b1;
        al_we     = l2_write_enable;
        al_addr   = l2_address;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("back_to_idle", {30'd0, c_state}, 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    write_enable    = 1'b0;
    read_enable     = 1'b0;
    request_address = '0;
    write_data      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {30'd0, c_state}, 32'd0);
    chk("rst_resp", response_data, 32'd0);
    chk("rst_l2_req", {31'd0, l2_request}, 32'd0);
    chk("rst_l2_we", {31'd0, l2_write_enable}, 32'd0);
    chk("rst_l2_addr", l2_address, 32'd0);
    chk("rst_l2_wdata", l2_write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cold miss then hit.
    req(1'b0, A, 32'd0);
    chk("t1_alloc_seen", {31'd0, saw_alloc}, 32'd1);
    chk("t1_alloc_addr", al_addr, 32'h0000_0830);
    chk("t1_alloc_we", {31'd0, al_we}, 32'd0);
    chk("t1_no_wb", {31'd0, saw_wb}, 32'd0);
    chk("t1_resp", response_data, 32'hEEEE_EEEE);
    chk("t1_miss_lat", {31'd0, cycles <= 5}, 32'd1);
    req(1'b0, A, 32'd0);
    chk("t1_hit_resp", response_data, 32'hEEEE_EEEE);
    chk("t1_hit_no_l2", {31'd0, saw_l2}, 32'd0);
    chk("t1_hit_lat", cycles, 32'd2);

    // LRU eviction: A most recently used, so C evicts B.
    req(1'b0, B, 32'd0);
    chk("t2_fill_b", response_data, 32'hFFFF_FFFF);
    req(1'b0, A, 32'd0);
    chk("t2_a_hit", {31'd0, saw_l2}, 32'd0);
    req(1'b0, C, 32'd0);
    chk("t2_c_alloc_addr", al_addr, 32'hAAAA_A830);
    chk("t2_c_resp", response_data, 32'hABCD_EFAB);
    req(1'b0, A, 32'd0);
    chk("t2_a_kept", {31'd0, saw_l2}, 32'd0);
    chk("t2_a_resp", response_data, 32'hEEEE_EEEE);
    req(1'b0, B, 32'd0);
    chk("t2_b_missed", {31'd0, saw_alloc}, 32'd1);
    chk("t2_b_resp", response_data, 32'hFFFF_FFFF);

    // Write hit: dirty, no L2 traffic, response unchanged.
    do_reset();
    req(1'b0, A, 32'd0);
    req(1'b0, B, 32'd0);
    req(1'b0, A, 32'd0);
    chk("t3_a_hit", {31'd0, saw_l2}, 32'd0);
    req(1'b0, B, 32'd0);
    chk("t3_b_hit", {31'd0, saw_l2}, 32'd0);
    req(1'b1, B, 32'hBEEF_DEAD);
    chk("t3_wr_no_l2", {31'd0, saw_l2}, 32'd0);
    chk("t3_wr_lat", cycles, 32'd2);
    chk("t3_wr_resp_held", response_data, 32'hFFFF_FFFF);

    // Clean eviction of A, then dirty eviction of B.
    req(1'b0, C, 32'd0);
    chk("t4_c_no_wb", {31'd0, saw_wb}, 32'd0);
    chk("t4_c_alloc_addr", al_addr, 32'hAAAA_A830);
    chk("t4_c_resp", response_data, 32'hABCD_EFAB);
    chk("t4_c_lat", {31'd0, cycles <= 5}, 32'd1);
    req(1'b0, D, 32'd0);
    chk("t4_d_wb_seen", {31'd0, saw_wb}, 32'd1);
    chk("t4_d_wb_we", {31'd0, wb_we}, 32'd1);
    chk("t4_d_wb_addr", wb_addr, 32'hABCD_E830);
    chk("t4_d_wb_data", wb_data, 32'hBEEF_DEAD);
    chk("t4_d_alloc_addr", al_addr, 32'hFFFF_F830);
    chk("t4_d_alloc_we", {31'd0, al_we}, 32'd0);
    chk("t4_d_resp", response_data, 32'hFEDC_BAFE);
    chk("t4_d_lat", {31'd0, cycles <= 8}, 32'd1);

    // Residents hit; evicted lines refill cleanly.
    req(1'b0, C, 32'd0);
    chk("t5_c_hit", {31'd0, saw_l2}, 32'd0);
    chk("t5_c_resp", response_data, 32'hABCD_EFAB);
    req(1'b0, D, 32'd0);
    chk("t5_d_hit", {31'd0, saw_l2}, 32'd0);
    chk("t5_d_resp", response_data, 32'hFEDC_BAFE);
    req(1'b0, A, 32'd0);
    chk("t5_a_no_wb", {31'd0, saw_wb}, 32'd0);
    chk("t5_a_resp", response_data, 32'hEEEE_EEEE);
    req(1'b0, B, 32'd0);
    chk("t5_b_no_wb", {31'd0, saw_wb}, 32'd0);
    chk("t5_b_resp", response_data, 32'hFFFF_FFFF);

    // Reset in the middle of a fill.
    do_reset();
    req(1'b0, A, 32'd0);
    @(negedge clk);
    read_enable     = 1'b1;
    request_address = B;
    @(posedge clk);
    #1;
    read_enable = 1'b0;
    chk("t6_compare", {30'd0, c_state}, 32'd1);
    @(posedge clk);
    #1;
    chk("t6_alloc", {30'd0, c_state}, 32'd2);
    chk("t6_alloc_req", {31'd0, l2_request}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_state", {30'd0, c_state}, 32'd0);
    chk("t6_rst_l2_req", {31'd0, l2_request}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req(1'b0, A, 32'd0);
    chk("t6_a_misses", {31'd0, saw_alloc}, 32'd1);
    chk("t6_a_resp", response_data, 32'hEEEE_EEEE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
